rst_sequencer: RTL and testbench

//  Parametrised reset manager between board-level reset sources and the SoC.

---
 rtl/rst_sequencer_pkg.sv | 20 ++
 rtl/rst_sequencer_debounce.sv | 47 ++++
 rtl/rst_sequencer.sv | 122 ++++++++++++
 tb/tb_rst_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: reset-cause codes, FSM states,
// and a small helper for sizing counters.
package rst_sequencer_pkg;

  localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
  localparam logic [1:0] RST_CAUSE_BTN  = 2'b01;
  localparam logic [1:0] RST_CAUSE_SW   = 2'b10;
  localparam logic [1:0] RST_CAUSE_TRAP = 2'b11;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_debounce.sv
// Push-button conditioner: multi-flop synchroniser followed by a stable-count
// debouncer; emits a single-cycle pulse when the debounced level rises.
module rst_sequencer_debounce #(
  parameter int DEBOUNCE    = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   btn_s;

  assign btn_s   = sync_q[SYNC_STAGES-1];
  assign press_o = press_q;

  // cnt_q counts down the remaining samples that must disagree with level_q
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= CNT_LOAD;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      press_q <= 1'b0;
      if (btn_s == level_q) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        level_q <= btn_s;
        press_q <= btn_s;
        cnt_q   <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Reset manager: stretches reset, releases N_OUT domains in order, and re-enters
// reset on button, software or trap requests while recording cause and count.
//
//   state      | meaning
//   ST_ASSERT  | all domains held in reset, hold counter running
//   ST_RELEASE | domains being released one per STAGGER cycles, index 0 first
//   ST_RUN     | all domains released, ready high, trap edges armed
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int N_OUT       = 3,
  parameter int HOLD_CYCLES = 65535,
  parameter int STAGGER     = 256,
  parameter int DEBOUNCE    = 100000,
  parameter int SYNC_STAGES = 2,
  parameter int TRAP_RST_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_rst,
  input  logic             sw_rst_req,
  input  logic             trap,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready,
  output logic [1:0]       rst_cause,
  output logic [7:0]       rst_count
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER) + 1);
  // Master reset loads one extra cycle because E0 is the edge after the last
  // reset edge; a request loads one fewer so rst_out[0] falls HOLD_CYCLES edges
  // after the edge that accepted it.
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_OUT-1:0] rst_out_q;
  logic             ready_q;
  logic [1:0]       cause_q;
  logic [7:0]       count_q;
  logic             trap_q;

  logic             btn_press;
  logic             trap_req;
  logic             req;
  logic [1:0]       req_cause;
  logic [N_OUT-1:0] rst_shift;

  rst_sequencer_debounce #(
    .DEBOUNCE    (DEBOUNCE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_debounce (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_rst),
    .press_o (btn_press)
  );

  assign trap_req  = (TRAP_RST_EN != 0) && (state_q == ST_RUN) && trap && !trap_q;
  assign req       = btn_press || sw_rst_req || trap_req;
  assign req_cause = btn_press  ? RST_CAUSE_BTN :
                     sw_rst_req ? RST_CAUSE_SW  : RST_CAUSE_TRAP;
  assign rst_shift = rst_out_q << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= HOLD_LOAD;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      cause_q   <= RST_CAUSE_POR;
      count_q   <= 8'd0;
      trap_q    <= 1'b0;
    end else begin
      trap_q <= trap;
      if (req) begin
        state_q   <= ST_ASSERT;
        cnt_q     <= HOLD_RELOAD;
        rst_out_q <= '1;
        ready_q   <= 1'b0;
        cause_q   <= req_cause;
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      end else begin
        case (state_q)
          ST_ASSERT, ST_RELEASE: begin
            // Shifting left clears the lowest still-asserted domain next.
            if (cnt_q == '0) begin
              rst_out_q <= rst_shift;
              cnt_q     <= STAGGER_LOAD;
              if (rst_shift == '0) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
              end else begin
                state_q <= ST_RELEASE;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_RUN: begin
            rst_out_q <= '0;
            ready_q   <= 1'b1;
          end
          default: begin
            state_q   <= ST_ASSERT;
            cnt_q     <= HOLD_RELOAD;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: power-on timing, software and button
// requests, request merging, trap gating and count saturation.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       trap = 1'b0;

  logic [2:0] rst_out,   rst_out_nt;
  logic       ready,     ready_nt;
  logic [1:0] rst_cause, rst_cause_nt;
  logic [7:0] rst_count, rst_count_nt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .N_OUT(3), .HOLD_CYCLES(8), .STAGGER(4), .DEBOUNCE(5), .SYNC_STAGES(2), .TRAP_RST_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_rst(btn_rst), .sw_rst_req(sw_rst_req), .trap(trap),
    .rst_out(rst_out), .ready(ready), .rst_cause(rst_cause), .rst_count(rst_count)
  );

  rst_sequencer #(
    .N_OUT(3), .HOLD_CYCLES(8), .STAGGER(4), .DEBOUNCE(5), .SYNC_STAGES(2), .TRAP_RST_EN(0)
  ) dut_nt (
    .clk(clk), .rst(rst), .btn_rst(btn_rst), .sw_rst_req(sw_rst_req), .trap(trap),
    .rst_out(rst_out_nt), .ready(ready_nt), .rst_cause(rst_cause_nt), .rst_count(rst_count_nt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1: power-on, rst high for three edges, then E0 is the first low edge
    tick(3);
    check_val("por_rst_out", rst_out, 3'b111);
    check_val("por_ready", ready, 1'b0);
    check_val("por_cause", rst_cause, 2'b00);
    check_val("por_count", rst_count, 8'd0);
    rst = 1'b0;
    for (int k = 0; k < 18; k++) begin
      tick(1);
      case (k)
        7:  check_val("e0p7_rst_out", rst_out, 3'b111);
        8:  check_val("e0p8_rst_out", rst_out, 3'b110);
        11: check_val("e0p11_rst_out", rst_out, 3'b110);
        12: check_val("e0p12_rst_out", rst_out, 3'b100);
        15: begin
          check_val("e0p15_rst_out", rst_out, 3'b100);
          check_val("e0p15_ready", ready, 1'b0);
        end
        16: begin
          check_val("e0p16_rst_out", rst_out, 3'b000);
          check_val("e0p16_ready", ready, 1'b1);
        end
        17: begin
          check_val("run_cause", rst_cause, 2'b00);
          check_val("run_count", rst_count, 8'd0);
        end
        default: ;
      endcase
    end

    // 3: software request at E0+10 while rst_out[0] is already released
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);
    check_val("sw_pre_rst_out", rst_out, 3'b110);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    check_val("sw_rst_out", rst_out, 3'b111);
    check_val("sw_ready", ready, 1'b0);
    check_val("sw_cause", rst_cause, 2'b10);
    check_val("sw_count", rst_count, 8'd1);
    tick(7);
    check_val("sw_r7_rst_out", rst_out, 3'b111);
    tick(1);
    check_val("sw_r8_rst_out", rst_out, 3'b110);
    tick(8);
    check_val("sw_r16_rst_out", rst_out, 3'b000);
    check_val("sw_r16_ready", ready, 1'b1);

    // 2: short button pulses are glitches, a long hold is one press
    for (int p = 0; p < 2; p++) begin
      btn_rst = 1'b1;
      tick(3);
      btn_rst = 1'b0;
      tick(10);
    end
    check_val("glitch_count", rst_count, 8'd1);
    check_val("glitch_rst_out", rst_out, 3'b000);
    btn_rst = 1'b1;
    tick(7);
    check_val("btn_t6_rst_out", rst_out, 3'b000);
    tick(1);
    check_val("btn_t7_rst_out", rst_out, 3'b111);
    check_val("btn_cause", rst_cause, 2'b01);
    check_val("btn_count", rst_count, 8'd2);
    tick(12);
    btn_rst = 1'b0;
    tick(40);
    check_val("btn_held_count", rst_count, 8'd2);
    check_val("btn_held_ready", ready, 1'b1);

    // 4: sw request and trap rise together give one reset with SW cause
    sw_rst_req = 1'b1;
    trap = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    check_val("both_rst_out", rst_out, 3'b111);
    check_val("both_cause", rst_cause, 2'b10);
    check_val("both_count", rst_count, 8'd3);
    tick(1);
    trap = 1'b0;
    tick(20);
    check_val("both_after_count", rst_count, 8'd3);
    check_val("both_after_ready", ready, 1'b1);

    // 5: trap rise in RUN resets only the trap-enabled instance
    trap = 1'b1;
    tick(1);
    check_val("trap_rst_out", rst_out, 3'b111);
    check_val("trap_cause", rst_cause, 2'b11);
    check_val("trap_count", rst_count, 8'd4);
    check_val("notrap_rst_out", rst_out_nt, 3'b000);
    check_val("notrap_ready", ready_nt, 1'b1);
    check_val("notrap_count", rst_count_nt, 8'd3);
    check_val("notrap_cause", rst_cause_nt, 2'b10);
    trap = 1'b0;
    tick(1);
    trap = 1'b1;
    tick(1);
    check_val("trap_in_assert_rst_out", rst_out, 3'b111);
    tick(20);
    check_val("trap_in_assert_count", rst_count, 8'd4);
    check_val("trap_in_assert_ready", ready, 1'b1);
    trap = 1'b0;
    tick(2);

    // 6: back-to-back sw requests saturate the counter; rst clears it
    sw_rst_req = 1'b1;
    tick(260);
    sw_rst_req = 1'b0;
    check_val("sat_count", rst_count, 8'd255);
    check_val("sat_rst_out", rst_out, 3'b111);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_val("clr_count", rst_count, 8'd0);
    check_val("clr_cause", rst_cause, 2'b00);
    check_val("clr_rst_out", rst_out, 3'b111);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
